// File: rtl/br_write_arbiter.sv
// Two-requester arbiter for the single BR write port: valid/ready handshake,
// round-robin grant with same-register collision priority, registered write stage.
// Optional saturating statistics counters are built when BR_ARB_STATS_EN is defined.
module br_write_arbiter #(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 5,
  parameter int unsigned COLLIDE_PRIO = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_stall,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_dir,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_dir,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  output logic [DW-1:0]    Di,
  output logic [AW-1:0]    Dir,
`ifdef BR_ARB_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] drop_cnt,
`endif
  output logic             Regw
);

  localparam logic PRIO_IS_1 = 1'(COLLIDE_PRIO);

  if (CNT_W == 0 || DW == 0 || AW == 0) begin : g_param_chk
    $error("br_write_arbiter: DW, AW and CNT_W must be nonzero");
  end

  logic          rr_ptr;
  logic          both_valid;
  logic          collide;
  logic          pick1;
  logic          grant0;
  logic          grant1;
  logic          any_grant;
  logic [AW-1:0] sel_dir;
  logic [DW-1:0] sel_data;

  // Grant selection; ready is forced low while in reset or stalled
  always_comb begin
    both_valid = req0_valid & req1_valid;
    collide    = both_valid & (req0_dir == req1_dir) & (req0_dir != '0);
    pick1      = collide ? PRIO_IS_1 : rr_ptr;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (rst_n && !wr_stall) begin
      if (both_valid) begin
        grant0 = ~pick1;
        grant1 = pick1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
    any_grant = grant0 | grant1;
    sel_dir   = grant1 ? req1_dir  : req0_dir;
    sel_data  = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Registered write stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Di     <= '0;
      Dir    <= '0;
      Regw   <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      Regw <= any_grant & (sel_dir != '0);
      if (any_grant) begin
        Di     <= sel_data;
        Dir    <= sel_dir;
        rr_ptr <= grant0;
      end
    end
  end

`ifdef BR_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating statistics; $zero writes count both as a grant and as a drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      drop_cnt   <= '0;
    end else begin
      if (grant0 && grant_cnt0 != CNT_MAX) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (grant1 && grant_cnt1 != CNT_MAX) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      if (any_grant && sel_dir == '0 && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_br_write_arbiter.sv
// Directed bench for br_write_arbiter: reset, single write, contention,
// collision, $zero drop and stall, with a simple BR register-file model.
module tb_br_write_arbiter;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_stall;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_dir, req1_dir;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] Di;
  logic [AW-1:0] Dir;
  logic          Regw;
`ifdef BR_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1, drop_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] br [32];

  always #5 clk = ~clk;

  br_write_arbiter #(.DW(DW), .AW(AW), .COLLIDE_PRIO(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_stall(wr_stall),
    .req0_valid(req0_valid), .req0_dir(req0_dir), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dir(req1_dir), .req1_data(req1_data), .req1_ready(req1_ready),
    .Di(Di), .Dir(Dir),
`ifdef BR_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .drop_cnt(drop_cnt),
`endif
    .Regw(Regw)
  );

  // BR model without $zero protection: any Regw to Dir=0 shows up as a nonzero BR[0]
  always @(posedge clk) if (Regw) br[Dir] <= Di;

  task automatic test_reset();
    rst_n = 1'b0; wr_stall = 1'b0;
    req0_valid = 1'b1; req0_dir = 5'd9; req0_data = 32'd77;
    req1_valid = 1'b0; req1_dir = '0;   req1_data = '0;
    #3;
    total_cnt++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0 got %0b want 0", req0_ready); else pass_cnt++;
    total_cnt++; if (Regw !== 1'b0 || Di !== 32'd0 || Dir !== 5'd0)
      $display("FAIL rst_outs got Regw=%0b Di=%0d Dir=%0d want 0/0/0", Regw, Di, Dir); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (Regw !== 1'b0) $display("FAIL rst_hold_regw got %0b want 0", Regw); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; #1;
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL rst_release_ready0 got %0b want 1", req0_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (Regw !== 1'b1 || Dir !== 5'd9 || Di !== 32'd77)
      $display("FAIL rst_first_write got Regw=%0b Dir=%0d Di=%0d want 1/9/77", Regw, Dir, Di); else pass_cnt++;
    // Assert reset mid-cycle while req0 is being granted
    #2 rst_n = 1'b0; #1;
    total_cnt++; if (Regw !== 1'b0 || Di !== 32'd0 || Dir !== 5'd0 || req0_ready !== 1'b0)
      $display("FAIL rst_midgrant got Regw=%0b Di=%0d Dir=%0d rdy=%0b want 0/0/0/0", Regw, Di, Dir, req0_ready);
    else pass_cnt++;
    @(negedge clk); req0_valid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic [AW-1:0] exp_dir;
    logic [DW-1:0] exp_di;
    req0_dir = 5'd2; req0_data = 32'd356; req1_dir = 5'd3; req1_data = 32'd646;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1))
        $display("FAIL cont_grant%0d got r0=%0b r1=%0b want r0=%0b", i, req0_ready, req1_ready, (i % 2 == 0));
      else pass_cnt++;
      exp_dir = (i % 2 == 0) ? 5'd2 : 5'd3;
      exp_di  = (i % 2 == 0) ? 32'd356 : 32'd646;
      @(posedge clk); #1;
      total_cnt++; if (Regw !== 1'b1 || Dir !== exp_dir || Di !== exp_di)
        $display("FAIL cont_write%0d got Regw=%0b Dir=%0d Di=%0d want 1/%0d/%0d", i, Regw, Dir, Di, exp_dir, exp_di);
      else pass_cnt++;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (Regw !== 1'b0 || Dir !== 5'd3 || Di !== 32'd646)
      $display("FAIL cont_idle got Regw=%0b Dir=%0d Di=%0d want 0/3/646", Regw, Dir, Di); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_dir = 5'd1; req0_data = 32'd255; #1;
    total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL single_ready got r0=%0b r1=%0b want 1/0", req0_ready, req1_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (Regw !== 1'b1 || Dir !== 5'd1 || Di !== 32'd255)
      $display("FAIL single_write got Regw=%0b Dir=%0d Di=%0d want 1/1/255", Regw, Dir, Di); else pass_cnt++;
    @(negedge clk); req0_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (Regw !== 1'b0 || Di !== 32'd255)
      $display("FAIL single_after got Regw=%0b Di=%0d want 0/255", Regw, Di); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_collision();
    // rr_ptr points at req1 here, so only the collision rule grants req0 first
    req0_valid = 1'b1; req0_dir = 5'd5; req0_data = 32'd149;
    req1_valid = 1'b1; req1_dir = 5'd5; req1_data = 32'd506; #1;
    total_cnt++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL coll_prio got r0=%0b r1=%0b want 1/0", req0_ready, req1_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (Regw !== 1'b1 || Dir !== 5'd5 || Di !== 32'd149)
      $display("FAIL coll_first got Regw=%0b Dir=%0d Di=%0d want 1/5/149", Regw, Dir, Di); else pass_cnt++;
    @(negedge clk); req0_valid = 1'b0; #1;
    total_cnt++; if (req1_ready !== 1'b1) $display("FAIL coll_ready1 got %0b want 1", req1_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (Regw !== 1'b1 || Dir !== 5'd5 || Di !== 32'd506)
      $display("FAIL coll_second got Regw=%0b Dir=%0d Di=%0d want 1/5/506", Regw, Dir, Di); else pass_cnt++;
    @(negedge clk); req1_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (br[5] !== 32'd506) $display("FAIL coll_br5 got %0d want 506", br[5]); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_zero_reg();
    req1_valid = 1'b1; req1_dir = 5'd0; req1_data = 32'd105; #1;
    total_cnt++; if (req1_ready !== 1'b1) $display("FAIL zero_ready1 got %0b want 1", req1_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (Regw !== 1'b0 || Dir !== 5'd0 || Di !== 32'd105)
      $display("FAIL zero_write got Regw=%0b Dir=%0d Di=%0d want 0/0/105", Regw, Dir, Di); else pass_cnt++;
    @(negedge clk); req1_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (br[0] !== 32'd0) $display("FAIL zero_br0 got %0d want 0", br[0]); else pass_cnt++;
`ifdef BR_ARB_STATS_EN
    total_cnt++; if (drop_cnt !== 16'd1) $display("FAIL zero_drop_cnt got %0d want 1", drop_cnt); else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic test_stall();
    wr_stall = 1'b1; req0_valid = 1'b1; req0_dir = 5'd7; req0_data = 32'd856;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL stall_ready%0d got r0=%0b r1=%0b want 0/0", i, req0_ready, req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (Regw !== 1'b0 || Dir !== 5'd0)
        $display("FAIL stall_regw%0d got Regw=%0b Dir=%0d want 0/0", i, Regw, Dir); else pass_cnt++;
      @(negedge clk);
    end
    wr_stall = 1'b0; #1;
    total_cnt++; if (req0_ready !== 1'b1) $display("FAIL stall_release_ready got %0b want 1", req0_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (Regw !== 1'b1 || Dir !== 5'd7 || Di !== 32'd856)
      $display("FAIL stall_write got Regw=%0b Dir=%0d Di=%0d want 1/7/856", Regw, Dir, Di); else pass_cnt++;
    // rr_ptr now favours req1 and must survive a stall with both requesters waiting
    @(negedge clk); wr_stall = 1'b1; req0_dir = 5'd8; req0_data = 32'd11;
    req1_valid = 1'b1; req1_dir = 5'd9; req1_data = 32'd22;
    @(negedge clk); wr_stall = 1'b0; #1;
    total_cnt++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1)
      $display("FAIL stall_rr_hold got r0=%0b r1=%0b want 0/1", req0_ready, req1_ready); else pass_cnt++;
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) br[i] = '0;
    test_reset();
    test_contention();
    test_single();
    test_collision();
    test_zero_reg();
    test_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
